// File: rtl/mem_stage_hs_pkg.sv
// Shared definitions for the MEM stage: bus widths, field offsets and load_op bit indices.
// Field offsets are LSB positions; every multi-bit field is read as [LSB +: width].
package mem_stage_hs_pkg;

    localparam int unsigned ES_BUS_W  = 200;
    localparam int unsigned MS_BUS_W  = 190;
    localparam int unsigned ECODE_W   = 15;
    localparam int unsigned CSR_W     = 103;
    localparam int unsigned CSR_NUM_W = 14;
    localparam int unsigned RF_BUS_W  = 5 + 32 + 3 + CSR_NUM_W;

    // load_op one-hot, written as {W,H,B,HU,BU}
    localparam int unsigned LD_W  = 4;
    localparam int unsigned LD_H  = 3;
    localparam int unsigned LD_B  = 2;
    localparam int unsigned LD_HU = 1;
    localparam int unsigned LD_BU = 0;

    typedef logic [4:0] load_op_t;

    // EXE->MEM bus; the top ES_BUS_W-ES_USED_W bits are reserved
    localparam int unsigned ES_ERTN       = 0;
    localparam int unsigned ES_ECODE_LSB  = 1;
    localparam int unsigned ES_EX         = 16;
    localparam int unsigned ES_CSR_LSB    = 17;
    localparam int unsigned ES_RFROM_MEM  = 120;
    localparam int unsigned ES_LOADOP_LSB = 121;
    localparam int unsigned ES_MEM_REQ    = 126;
    localparam int unsigned ES_RESULT_LSB = 127;
    localparam int unsigned ES_DEST_LSB   = 159;
    localparam int unsigned ES_GR_WE      = 164;
    localparam int unsigned ES_PC_LSB     = 165;
    localparam int unsigned ES_USED_W     = 197;

    // MEM->WB bus
    localparam int unsigned MS_ERTN       = 0;
    localparam int unsigned MS_ECODE_LSB  = 1;
    localparam int unsigned MS_EX         = 16;
    localparam int unsigned MS_CSR_LSB    = 17;
    localparam int unsigned MS_RESULT_LSB = 120;
    localparam int unsigned MS_DEST_LSB   = 152;
    localparam int unsigned MS_GR_WE      = 157;
    localparam int unsigned MS_PC_LSB     = 158;

endpackage

// File: rtl/mem_stage_hs_ld_extract.sv
// Load data extraction: shift the selected response word to the byte offset, then
// sign- or zero-extend according to the one-hot load_op.
module mem_stage_hs_ld_extract
    import mem_stage_hs_pkg::*;
#(
    parameter int unsigned DATA_W = 32,
    localparam int unsigned OFF_W = $clog2(DATA_W / 8)
) (
    input  logic [DATA_W-1:0] rdata_sel,
    input  logic [OFF_W-1:0]  offset,
    input  logic [4:0]        load_op,
    output logic [31:0]       load
);

    logic [DATA_W-1:0] sh;

    assign sh = rdata_sel >> {offset, 3'b000};

    always_comb begin
        load = 32'h0;
        unique case (1'b1)
            load_op[LD_W]:  load = sh[31:0];
            load_op[LD_H]:  load = {{16{sh[15]}}, sh[15:0]};
            load_op[LD_B]:  load = {{24{sh[7]}}, sh[7:0]};
            load_op[LD_HU]: load = {16'h0, sh[15:0]};
            load_op[LD_BU]: load = {24'h0, sh[7:0]};
            default:        load = 32'h0;
        endcase
    end

    if (DATA_W > 32) begin : g_wide
        logic unused_sh_hi;
        assign unused_sh_hi = ^sh[DATA_W-1:32];
    end

endmodule

// File: rtl/mem_stage_hs.sv
// MEM stage with a request/response data interface: tracks outstanding requests, drops responses
// of flushed requests, buffers a load result while WB stalls. Optional MS_PERF_CNT_EN adds ms_stall_cnt.
module mem_stage_hs #(
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned MAX_OUTS = 2,
    parameter int unsigned ES_BUS_W = mem_stage_hs_pkg::ES_BUS_W,
    parameter int unsigned MS_BUS_W = mem_stage_hs_pkg::MS_BUS_W
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic                                es_to_ms_valid,
    input  logic [ES_BUS_W-1:0]                 es_to_ms_bus,
    output logic                                ms_allowin,
    input  logic                                ws_allowin,
    output logic                                ms_to_ws_valid,
    output logic [MS_BUS_W-1:0]                 ms_to_ws_bus,
    output logic [mem_stage_hs_pkg::RF_BUS_W-1:0] ms_rf_bus,
    input  logic                                req_accept,
    input  logic                                data_ok,
    input  logic [DATA_W-1:0]                   rdata,
    input  logic                                flush,
    output logic                                ms_ex,
    output logic                                ms_ertn
`ifdef MS_PERF_CNT_EN
    ,
    output logic [31:0]                         ms_stall_cnt
`endif
);

    import mem_stage_hs_pkg::*;

    localparam int unsigned OFF_W = $clog2(DATA_W / 8);
    localparam int unsigned CNT_W = $clog2(MAX_OUTS + 1);

    logic                ms_valid_q;
    logic [ES_BUS_W-1:0] es_bus_q;
    logic [CNT_W-1:0]    outs_cnt_q, outs_cnt_d;
    logic [CNT_W-1:0]    discard_cnt_q, discard_cnt_d;
    logic                data_got_q;
    logic [DATA_W-1:0]   rdata_buf_q;

    logic [31:0]        f_pc, f_result, final_result, load_val;
    logic [4:0]         f_dest;
    logic [4:0]         f_load_op;
    logic [CSR_W-1:0]   f_csr;
    logic [ECODE_W-1:0] f_ecode;
    logic               f_gr_we, f_mem_req, f_rfrom_mem, f_ex, f_ertn;
    logic               resp_accept, ready_go, ms_leave, ms_data_pending;
    logic [DATA_W-1:0]  rdata_sel;

    assign f_pc        = es_bus_q[ES_PC_LSB +: 32];
    assign f_gr_we     = es_bus_q[ES_GR_WE];
    assign f_dest      = es_bus_q[ES_DEST_LSB +: 5];
    assign f_result    = es_bus_q[ES_RESULT_LSB +: 32];
    assign f_mem_req   = es_bus_q[ES_MEM_REQ];
    assign f_load_op   = es_bus_q[ES_LOADOP_LSB +: 5];
    assign f_rfrom_mem = es_bus_q[ES_RFROM_MEM];
    assign f_csr       = es_bus_q[ES_CSR_LSB +: CSR_W];
    assign f_ex        = es_bus_q[ES_EX];
    assign f_ecode     = es_bus_q[ES_ECODE_LSB +: ECODE_W];
    assign f_ertn      = es_bus_q[ES_ERTN];

    logic unused_es_rsvd;
    assign unused_es_rsvd = ^es_bus_q[ES_BUS_W-1:ES_USED_W];

    // A response belongs to the current entry only once every flushed request has drained.
    assign resp_accept = data_ok && (discard_cnt_q == '0) && ms_valid_q && f_mem_req && !data_got_q;
    assign ready_go    = !f_mem_req || f_ex || data_got_q || resp_accept;

    assign ms_allowin      = !ms_valid_q || (ready_go && ws_allowin);
    assign ms_to_ws_valid  = ms_valid_q && ready_go;
    assign ms_leave        = ms_to_ws_valid && ws_allowin;
    assign ms_data_pending = ms_valid_q && f_rfrom_mem && !ready_go;
    assign ms_ex           = f_ex && ms_valid_q;
    assign ms_ertn         = f_ertn && ms_valid_q;

    assign rdata_sel = data_got_q ? rdata_buf_q : rdata;

    mem_stage_hs_ld_extract #(
        .DATA_W (DATA_W)
    ) u_ld_extract (
        .rdata_sel (rdata_sel),
        .offset    (f_result[OFF_W-1:0]),
        .load_op   (f_load_op),
        .load      (load_val)
    );

    assign final_result = f_rfrom_mem ? load_val : f_result;

    assign ms_to_ws_bus = {f_pc, f_gr_we, f_dest, final_result, f_csr, f_ex, f_ecode, f_ertn};

    assign ms_rf_bus = {f_dest & {5{f_gr_we && ms_valid_q}}, final_result, ms_valid_q,
                        ms_data_pending, f_csr[CSR_W-1], f_csr[CSR_W-2 -: CSR_NUM_W]};

    always_comb begin
        outs_cnt_d = outs_cnt_q;
        if (req_accept && !data_ok) begin
            outs_cnt_d = outs_cnt_q + CNT_W'(1);
        end else if (!req_accept && data_ok) begin
            outs_cnt_d = outs_cnt_q - CNT_W'(1);
        end
    end

    // On flush everything still in flight after this cycle is stale, including EXE's new request.
    always_comb begin
        discard_cnt_d = discard_cnt_q;
        if (flush) begin
            discard_cnt_d = outs_cnt_d;
        end else if (data_ok && discard_cnt_q != '0) begin
            discard_cnt_d = discard_cnt_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ms_valid_q    <= 1'b0;
            es_bus_q      <= '0;
            outs_cnt_q    <= '0;
            discard_cnt_q <= '0;
            data_got_q    <= 1'b0;
            rdata_buf_q   <= '0;
        end else begin
            outs_cnt_q    <= outs_cnt_d;
            discard_cnt_q <= discard_cnt_d;
            if (flush) begin
                ms_valid_q <= 1'b0;
            end else if (ms_allowin) begin
                ms_valid_q <= es_to_ms_valid;
            end
            if (es_to_ms_valid && ms_allowin) begin
                es_bus_q <= es_to_ms_bus;
            end
            if (flush || ms_leave) begin
                data_got_q <= 1'b0;
            end else if (resp_accept && !ws_allowin) begin
                data_got_q  <= 1'b1;
                rdata_buf_q <= rdata;
            end
        end
    end

`ifdef MS_PERF_CNT_EN
    logic [31:0] stall_cnt_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt_q <= 32'h0;
        end else if (ms_valid_q && !ready_go && stall_cnt_q != 32'hFFFF_FFFF) begin
            stall_cnt_q <= stall_cnt_q + 32'h1;
        end
    end

    assign ms_stall_cnt = stall_cnt_q;
`endif

    outs_overflow_a: assert property (@(posedge clk) disable iff (reset)
        !(req_accept && outs_cnt_q == CNT_W'(MAX_OUTS)));

endmodule

// File: tb/tb_mem_stage_hs.sv
// Directed bench for mem_stage_hs: a 32-bit and a 64-bit instance share one stimulus stream.
module tb_mem_stage_hs;

    import mem_stage_hs_pkg::*;

    localparam logic [4:0] OP_W  = 5'b10000;
    localparam logic [4:0] OP_H  = 5'b01000;
    localparam logic [4:0] OP_B  = 5'b00100;
    localparam logic [4:0] OP_HU = 5'b00010;
    localparam logic [4:0] OP_BU = 5'b00001;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                reset, es_to_ms_valid, ws_allowin, req_accept, data_ok, flush;
    logic [ES_BUS_W-1:0] es_to_ms_bus;
    logic [63:0]         rdata64;

    logic                ms_allowin_32, ms_to_ws_valid_32, ms_ex_32, ms_ertn_32;
    logic [MS_BUS_W-1:0] ms_to_ws_bus_32;
    logic [RF_BUS_W-1:0] ms_rf_bus_32;
    logic                ms_allowin_64, ms_to_ws_valid_64, ms_ex_64, ms_ertn_64;
    logic [MS_BUS_W-1:0] ms_to_ws_bus_64;
    logic [RF_BUS_W-1:0] ms_rf_bus_64;
`ifdef MS_PERF_CNT_EN
    logic [31:0]         stall_cnt_32, stall_cnt_64, stall_start;
`endif

    int checks = 0;
    int errors = 0;

    mem_stage_hs #(
        .DATA_W (32)
    ) u_dut32 (
        .clk            (clk),
        .reset          (reset),
        .es_to_ms_valid (es_to_ms_valid),
        .es_to_ms_bus   (es_to_ms_bus),
        .ms_allowin     (ms_allowin_32),
        .ws_allowin     (ws_allowin),
        .ms_to_ws_valid (ms_to_ws_valid_32),
        .ms_to_ws_bus   (ms_to_ws_bus_32),
        .ms_rf_bus      (ms_rf_bus_32),
        .req_accept     (req_accept),
        .data_ok        (data_ok),
        .rdata          (rdata64[31:0]),
        .flush          (flush),
        .ms_ex          (ms_ex_32),
        .ms_ertn        (ms_ertn_32)
`ifdef MS_PERF_CNT_EN
        ,
        .ms_stall_cnt   (stall_cnt_32)
`endif
    );

    mem_stage_hs #(
        .DATA_W (64)
    ) u_dut64 (
        .clk            (clk),
        .reset          (reset),
        .es_to_ms_valid (es_to_ms_valid),
        .es_to_ms_bus   (es_to_ms_bus),
        .ms_allowin     (ms_allowin_64),
        .ws_allowin     (ws_allowin),
        .ms_to_ws_valid (ms_to_ws_valid_64),
        .ms_to_ws_bus   (ms_to_ws_bus_64),
        .ms_rf_bus      (ms_rf_bus_64),
        .req_accept     (req_accept),
        .data_ok        (data_ok),
        .rdata          (rdata64),
        .flush          (flush),
        .ms_ex          (ms_ex_64),
        .ms_ertn        (ms_ertn_64)
`ifdef MS_PERF_CNT_EN
        ,
        .ms_stall_cnt   (stall_cnt_64)
`endif
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [ES_BUS_W-1:0] make_es(
        input logic [31:0] pc, input logic gr_we, input logic [4:0] dest,
        input logic [31:0] res, input logic mem_req, input logic [4:0] lop,
        input logic rfm, input logic ex, input logic [14:0] ecode, input logic ertn,
        input logic csr_we, input logic [13:0] csr_num);
        logic [ES_BUS_W-1:0] b;
        b = '0;
        b[ES_PC_LSB +: 32]     = pc;
        b[ES_GR_WE]            = gr_we;
        b[ES_DEST_LSB +: 5]    = dest;
        b[ES_RESULT_LSB +: 32] = res;
        b[ES_MEM_REQ]          = mem_req;
        b[ES_LOADOP_LSB +: 5]  = lop;
        b[ES_RFROM_MEM]        = rfm;
        b[ES_EX]               = ex;
        b[ES_ECODE_LSB +: 15]  = ecode;
        b[ES_ERTN]             = ertn;
        b[ES_CSR_LSB + CSR_W - 1]      = csr_we;
        b[ES_CSR_LSB + CSR_W - 2 -: 14] = csr_num;
        return b;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; es_to_ms_valid = 1'b0; es_to_ms_bus = '0; ws_allowin = 1'b1;
        req_accept = 1'b0; data_ok = 1'b0; flush = 1'b0; rdata64 = '0;
        tick(); tick();
        reset = 1'b0;
        #1;
        check("rst_valid", ms_to_ws_valid_32, 0);
        check("rst_allowin", ms_allowin_32, 1);
        check("rst_ex", ms_ex_32, 0);
        check("rst_ertn", ms_ertn_32, 0);
        check("rst_rf_bus", ms_rf_bus_32, 0);
        check("rst_ws_bus", ms_to_ws_bus_32 == '0, 1);
`ifdef MS_PERF_CNT_EN
        check("rst_stall_cnt", stall_cnt_32, 0);
`endif

        // ld.b on the 64-bit bus, byte 5 = 0x80, response three cycles late
        tick();
        es_to_ms_valid = 1'b1; req_accept = 1'b1;
        es_to_ms_bus = make_es(32'h1c00_0100, 1, 5'd3, 32'h0000_1005, 1, OP_B, 1, 0, 0, 0, 0, 0);
        tick();
        es_to_ms_valid = 1'b0; req_accept = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("ldb_wait_valid", ms_to_ws_valid_64, 0);
            check("ldb_wait_pending", ms_rf_bus_64[15], 1);
            check("ldb_wait_allowin", ms_allowin_64, 0);
            tick();
        end
        data_ok = 1'b1; rdata64 = 64'h0000_8000_0000_0000;
        #1;
        check("ldb_valid", ms_to_ws_valid_64, 1);
        check("ldb_result", ms_to_ws_bus_64[MS_RESULT_LSB +: 32], 32'hFFFF_FF80);
        check("ldb_pending_clr", ms_rf_bus_64[15], 0);
        check("ldb_rf_dest", ms_rf_bus_64[53:49], 5'd3);
        tick();
        data_ok = 1'b0; rdata64 = '0;
        #1;
        check("ldb_gone", ms_to_ws_valid_64, 0);

        // ld.hu at offset 2, response arrives while WB is stalled
        tick();
        es_to_ms_valid = 1'b1; req_accept = 1'b1;
        es_to_ms_bus = make_es(32'h1c00_0104, 1, 5'd4, 32'h0000_2002, 1, OP_HU, 1, 0, 0, 0, 0, 0);
        tick();
        es_to_ms_valid = 1'b0; req_accept = 1'b0;
        ws_allowin = 1'b0; data_ok = 1'b1; rdata64 = 64'h0000_0000_8001_1234;
        #1;
        check("ldhu_valid_stall", ms_to_ws_valid_32, 1);
        check("ldhu_allowin_stall", ms_allowin_32, 0);
        tick();
        data_ok = 1'b0; rdata64 = 64'hDEAD_BEEF_DEAD_BEEF;
        #1;
        check("ldhu_buf_valid", ms_to_ws_valid_32, 1);
        check("ldhu_buf_result", ms_to_ws_bus_32[MS_RESULT_LSB +: 32], 32'h0000_8001);
        tick();
        ws_allowin = 1'b1;
        #1;
        check("ldhu_result32", ms_to_ws_bus_32[MS_RESULT_LSB +: 32], 32'h0000_8001);
        check("ldhu_result64", ms_to_ws_bus_64[MS_RESULT_LSB +: 32], 32'h0000_8001);
        check("ldhu_allowin", ms_allowin_32, 1);
        tick();
        rdata64 = '0;
        #1;
        check("ldhu_gone", ms_to_ws_valid_32, 0);

        // two requests in flight, flush, two stale responses dropped, third one used
        tick();
        es_to_ms_valid = 1'b1; req_accept = 1'b1;
        es_to_ms_bus = make_es(32'h1c00_0108, 1, 5'd5, 32'h0000_3000, 1, OP_W, 1, 0, 0, 0, 0, 0);
        tick();
        es_to_ms_bus = make_es(32'h1c00_010c, 1, 5'd6, 32'h0000_3004, 1, OP_W, 1, 0, 0, 0, 0, 0);
        tick();
        es_to_ms_valid = 1'b0; req_accept = 1'b0; flush = 1'b1;
        tick();
        flush = 1'b0;
        es_to_ms_valid = 1'b1;
        es_to_ms_bus = make_es(32'h1c00_0110, 1, 5'd8, 32'h0000_3000, 1, OP_W, 1, 0, 0, 0, 0, 0);
        data_ok = 1'b1; rdata64 = 64'h1111_1111;
        #1;
        check("disc_flushed_valid", ms_to_ws_valid_32, 0);
        tick();
        es_to_ms_valid = 1'b0; req_accept = 1'b1; rdata64 = 64'h2222_2222;
        #1;
        check("disc_second_dropped", ms_to_ws_valid_32, 0);
        check("disc_pending", ms_rf_bus_32[15], 1);
        tick();
        req_accept = 1'b0; rdata64 = 64'h0000_00A5;
        #1;
        check("disc_third_valid", ms_to_ws_valid_32, 1);
        check("disc_third_result", ms_to_ws_bus_32[MS_RESULT_LSB +: 32], 32'h0000_00A5);
        tick();
        data_ok = 1'b0; rdata64 = '0;
        #1;
        check("disc_gone", ms_to_ws_valid_32, 0);

        // flush, req_accept and data_ok together with one request outstanding
        tick();
        es_to_ms_valid = 1'b1; req_accept = 1'b1;
        es_to_ms_bus = make_es(32'h1c00_0114, 1, 5'd9, 32'h0000_4000, 1, OP_W, 1, 0, 0, 0, 0, 0);
        tick();
        es_to_ms_valid = 1'b0;
        flush = 1'b1; data_ok = 1'b1; rdata64 = 64'h3333_3333;
        tick();
        flush = 1'b0; req_accept = 1'b0; data_ok = 1'b0;
        es_to_ms_valid = 1'b1;
        es_to_ms_bus = make_es(32'h1c00_0118, 1, 5'd10, 32'h0000_5000, 1, OP_W, 1, 0, 0, 0, 0, 0);
        #1;
        check("sim_flush_empty", ms_to_ws_valid_32, 0);
        check("sim_flush_allowin", ms_allowin_32, 1);
        tick();
        es_to_ms_valid = 1'b0; data_ok = 1'b1; rdata64 = 64'h4444_4444;
        #1;
        check("sim_stale_dropped", ms_to_ws_valid_32, 0);
        tick();
        data_ok = 1'b0; req_accept = 1'b1;
        #1;
        check("sim_wait_valid", ms_to_ws_valid_32, 0);
        check("sim_wait_pending", ms_rf_bus_32[15], 1);
        tick();
        req_accept = 1'b0; data_ok = 1'b1; rdata64 = 64'h1234_5678;
        #1;
        check("sim_new_valid", ms_to_ws_valid_32, 1);
        check("sim_new_result", ms_to_ws_bus_32[MS_RESULT_LSB +: 32], 32'h1234_5678);
        tick();
        data_ok = 1'b0; rdata64 = '0;

        // ALU op passes through in one cycle
        es_to_ms_valid = 1'b1;
        es_to_ms_bus = make_es(32'h1c00_0200, 1, 5'd7, 32'hCAFE_F00D, 0, 5'b0, 0, 0, 0, 0,
                               1, 14'h0123);
        tick();
        es_to_ms_valid = 1'b0;
        #1;
        check("alu_valid", ms_to_ws_valid_32, 1);
        check("alu_result", ms_to_ws_bus_32[MS_RESULT_LSB +: 32], 32'hCAFE_F00D);
        check("alu_pc", ms_to_ws_bus_32[MS_PC_LSB +: 32], 32'h1c00_0200);
        check("alu_rf_dest", ms_rf_bus_32[53:49], 5'd7);
        check("alu_rf_csr_we", ms_rf_bus_32[14], 1);
        check("alu_rf_csr_num", ms_rf_bus_32[13:0], 14'h0123);
        check("alu_allowin", ms_allowin_32, 1);
        tick();
        #1;
        check("alu_gone", ms_to_ws_valid_32, 0);

        // excepting load never waits for data
        tick();
        es_to_ms_valid = 1'b1;
        es_to_ms_bus = make_es(32'h1c00_0204, 1, 5'd9, 32'h0000_6000, 1, OP_W, 1, 1, 15'h0040,
                               0, 0, 0);
        tick();
        es_to_ms_valid = 1'b0;
        #1;
        check("ex_ms_ex", ms_ex_32, 1);
        check("ex_ms_ex64", ms_ex_64, 1);
        check("ex_valid", ms_to_ws_valid_32, 1);
        check("ex_ecode", ms_to_ws_bus_32[MS_ECODE_LSB +: 15], 15'h0040);
        check("ex_pending", ms_rf_bus_32[15], 0);
        tick();
        #1;
        check("ex_gone", ms_ex_32, 0);

        // ertn with gr_we=0 held one cycle by WB
        tick();
        es_to_ms_valid = 1'b1;
        es_to_ms_bus = make_es(32'h1c00_0208, 0, 5'd5, 32'h0, 0, 5'b0, 0, 0, 0, 1, 0, 0);
        tick();
        es_to_ms_valid = 1'b0; ws_allowin = 1'b0;
        #1;
        check("ertn_flag", ms_ertn_32, 1);
        check("ertn_dest_masked", ms_rf_bus_32[53:49], 5'd0);
        check("ertn_hold_allowin", ms_allowin_32, 0);
        tick();
        ws_allowin = 1'b1;
        #1;
        check("ertn_still", ms_ertn_64, 1);
        tick();
        #1;
        check("ertn_gone", ms_ertn_32, 0);

`ifdef MS_PERF_CNT_EN
        // four-cycle load wait adds four to the stall counter
        tick();
        stall_start = stall_cnt_32;
        es_to_ms_valid = 1'b1; req_accept = 1'b1;
        es_to_ms_bus = make_es(32'h1c00_0300, 1, 5'd2, 32'h0000_7000, 1, OP_BU, 1, 0, 0, 0, 0, 0);
        tick();
        es_to_ms_valid = 1'b0; req_accept = 1'b0;
        repeat (4) tick();
        data_ok = 1'b1; rdata64 = 64'h0000_00F0;
        #1;
        check("perf_bu_result", ms_to_ws_bus_32[MS_RESULT_LSB +: 32], 32'h0000_00F0);
        tick();
        data_ok = 1'b0;
        check("perf_stall_delta", stall_cnt_32 - stall_start, 4);
        check("perf_stall_64", stall_cnt_64, stall_cnt_32);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_stage_hs.md
Name: mem_stage_hs

Overview:
Parametrised MEM pipeline stage for the LoongArch-style 5-stage core. It replaces the fixed single-cycle-SRAM MEM stage with a request/response data-memory interface: variable load latency, multiple outstanding requests, and a DATA_W-wide read bus. It extracts and extends load data, forwards results to decode, and on flush discards responses that belong to cancelled requests.

Parameters:
DATA_W, 32, data-bus width in bits; 32 or 64; byte-lane offset width OFF_W = log2(DATA_W/8)
MAX_OUTS, 2, maximum outstanding data requests; counters are clog2(MAX_OUTS+1) bits
ES_BUS_W, 200, EXE->MEM bus width (value from shared package)
MS_BUS_W, 190, MEM->WB bus width (value from shared package)

Ports:
clk  in  1  clock, rising edge
reset  in  1  synchronous, active-high reset
es_to_ms_valid  in  1  EXE has an instruction for MEM
es_to_ms_bus  in  ES_BUS_W  fields: pc, gr_we, dest, exe_result, mem_req, load_op[4:0], rfrom_mem, csr payload, ex, ecode[14:0], ertn
ms_allowin  out  1  MEM can accept this cycle
ws_allowin  in  1  WB can accept
ms_to_ws_valid  out  1  MEM result valid to WB
ms_to_ws_bus  out  MS_BUS_W  pc, gr_we, dest, final_result, csr payload, ex, ecode, ertn
ms_rf_bus  out  5+32+3+14  {dest masked by gr_we&ms_valid, final_result, ms_valid, ms_data_pending, csr_we, csr_num}
req_accept  in  1  one-cycle pulse: a data request address handshake completed in EXE
data_ok  in  1  data response valid
rdata  in  DATA_W  response data
flush  in  1  ertn_flush | wb_ex
ms_ex  out  1  ex & ms_valid
ms_ertn  out  1  ertn & ms_valid

Behaviour:
- Reset: ms_valid=0, bus register 0, outs_cnt=0, discard_cnt=0, data_got=0, rdata_buf=0. All outputs derive from these, so ms_to_ws_valid, ms_ex and ms_ertn are 0.
- Pipeline:
  - ms_allowin = !ms_valid | (ready_go & ws_allowin)
  - ms_to_ws_valid = ms_valid & ready_go
  - Bus latched when es_to_ms_valid & ms_allowin.
- outs_cnt:
  - +1 on req_accept; -1 on any data_ok; both in the same cycle leaves it unchanged.
  - req_accept while outs_cnt==MAX_OUTS is illegal: assertion fails.
- Accepted response: data_ok & discard_cnt==0 & ms_valid & mem_req & !data_got.
  - If ws_allowin=0 that cycle: rdata goes into rdata_buf and data_got is set.
  - data_got clears when the entry leaves MEM.
- ready_go = !mem_req | ex | data_got | accepted-response. Excepting instructions never wait.
- ms_data_pending = ms_valid & rfrom_mem & !ready_go. Decode stalls on a dest match while this is set.
- Flush:
  - ms_valid <= 0; data_got <= 0.
  - discard_cnt <= outs_cnt + req_accept - data_ok. This counts every request still in flight, including the current MEM entry's and any just issued by EXE.
- Discard: data_ok while discard_cnt>0 decrements discard_cnt and is never used as load data. New entries wait until discard_cnt==0.
- Load extraction:
  - sh = rdata_sel >> (exe_result[OFF_W-1:0]*8), where rdata_sel = data_got ? rdata_buf : rdata.
  - load_op one-hot {W,H,B,HU,BU}: B/H sign-extend, BU/HU zero-extend, W takes the low 32 bits.
  - final_result = rfrom_mem ? load : exe_result.
- Simultaneous events: flush plus data_ok in the same cycle leaves that response counted as consumed, which the formula above already reflects. Reset mid-request clears all counters; the memory side is reset together with the core.

Optional Feature:
MS_PERF_CNT_EN
- Defined: adds output ms_stall_cnt (32 bits). It counts cycles with ms_valid & !ready_go, resets to 0, and saturates at all-ones.
- Undefined: the port and counter do not exist; all other behaviour is identical.

Decomposition:
- Shared package/header holds:
  - ES_BUS_W and MS_BUS_W.
  - Bus field offsets.
  - load_op bit indices LD_W, LD_H, LD_B, LD_HU, LD_BU.
  - ECODE width.
- One sub-module: ld_extract (combinational). Inputs: rdata_sel, offset, load_op. Output: 32-bit load value. Parametrised on DATA_W.

Test Plan:
- ld.b, DATA_W=64, exe_result[2:0]=5, rdata=0x..80_0000_0000, data_ok after 3 cycles -> ready_go=0 for 3 cycles, ms_data_pending=1, then final_result=0xFFFFFF80.
- ld.hu, DATA_W=32, addr offset 2, rdata=0x8001_1234, data_ok while ws_allowin=0 -> buffered; on ws_allowin=1 in a later cycle, final_result=0x00008001.
- Two req_accept, then flush before any data_ok -> discard_cnt=2; next two data_ok ignored; a new load then completes with the third response.
- flush, req_accept and data_ok in the same cycle with outs_cnt=1 -> discard_cnt=1, outs_cnt=1.
- Store or ALU op (mem_req=0) with ws_allowin=1 -> passes in 1 cycle; ex=1 on a load -> ms_ex=1 with no wait for data_ok.
- MS_PERF_CNT_EN build: 4-cycle load wait -> ms_stall_cnt increments by 4.
